// File: rtl/irq_priority_ctrl.sv
// Priority interrupt controller: edge capture, mask/enable, INT/NMI handshake.
// Define IRQ_ROUND_ROBIN_EN for rotating priority instead of fixed priority.
module irq_priority_ctrl #(
   parameter int unsigned      NUM_IRQ     = 8,
   parameter int unsigned      VEC_W       = 8,
   parameter logic [VEC_W-1:0] BASE_VECTOR = VEC_W'('h20),
   parameter logic [VEC_W-1:0] NMI_VECTOR  = VEC_W'('h02)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               nmi_in,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               int_en,
   output logic               cpu_int,
   output logic               cpu_nmi,
   input  logic               cpu_ina,
   input  logic               cpu_eoi,
   output logic [VEC_W-1:0]   vector,
   output logic               busy,
   output logic [NUM_IRQ-1:0] pending
);

   localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_SERV  = 3'd2;
   localparam logic [2:0] S_NREQ  = 3'd3;
   localparam logic [2:0] S_NSERV = 3'd4;

   logic [2:0]         r_state;
   logic [NUM_IRQ-1:0] r_irq_prev;
   logic [NUM_IRQ-1:0] r_pend;
   logic               r_nmi_prev;
   logic               r_nmi_p;
   logic               r_armed;
   logic               r_src_nmi;
   logic [IW-1:0]      r_chan;
   logic [VEC_W-1:0]   r_vec;
   logic [VEC_W-1:0]   r_save_vec;
   logic               r_int;
   logic               r_nmi;
   logic               r_busy;

   logic [NUM_IRQ-1:0] w_edge;
   logic [NUM_IRQ-1:0] w_elig;
   logic [NUM_IRQ-1:0] w_pclr;
   logic               w_nmi_edge;
   logic               w_nmi_clr;
   logic               w_ack_m;
   logic [IW-1:0]      w_win;
   logic               w_any;

   // Lines already high when reset releases are levels, not fresh edges.
   assign w_edge     = irq_in & ~r_irq_prev & {NUM_IRQ{r_armed}};
   assign w_nmi_edge = nmi_in & ~r_nmi_prev & r_armed;
   assign w_elig     = r_pend & ~irq_mask & {NUM_IRQ{int_en}};
   assign w_ack_m    = (r_state == S_REQ) & cpu_ina & ~r_src_nmi;
   assign w_pclr     = w_ack_m ? (NUM_IRQ'(1) << r_chan) : '0;
   assign w_nmi_clr  = cpu_ina & (((r_state == S_REQ) & r_src_nmi)
                                  | (r_state == S_NREQ));

`ifdef IRQ_ROUND_ROBIN_EN
   logic [IW-1:0] r_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= IW'(NUM_IRQ - 1);
      else if (w_ack_m)
         r_ptr <= r_chan;
   end

   // Walk backwards so the closest channel after the pointer wins.
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
         if (w_elig[IW'((int'(r_ptr) + 1 + k) % int'(NUM_IRQ))]) begin
            w_win = IW'((int'(r_ptr) + 1 + k) % int'(NUM_IRQ));
            w_any = 1'b1;
         end
      end
   end
`else
   always_comb begin
      w_win = '0;
      w_any = 1'b0;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_win = IW'(i);
            w_any = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq_prev <= '0;
         r_nmi_prev <= 1'b0;
         r_armed    <= 1'b0;
         r_pend     <= '0;
         r_nmi_p    <= 1'b0;
      end else begin
         r_irq_prev <= irq_in;
         r_nmi_prev <= nmi_in;
         r_armed    <= 1'b1;
         r_pend     <= (r_pend & ~w_pclr) | w_edge;
         r_nmi_p    <= (r_nmi_p & ~w_nmi_clr) | w_nmi_edge;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_src_nmi  <= 1'b0;
         r_chan     <= '0;
         r_vec      <= '0;
         r_save_vec <= '0;
         r_int      <= 1'b0;
         r_nmi      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_nmi_p) begin
                  r_state   <= S_REQ;
                  r_src_nmi <= 1'b1;
                  r_vec     <= NMI_VECTOR;
                  r_nmi     <= 1'b1;
               end else if (w_any) begin
                  r_state   <= S_REQ;
                  r_src_nmi <= 1'b0;
                  r_chan    <= w_win;
                  r_vec     <= BASE_VECTOR + VEC_W'(w_win);
                  r_int     <= 1'b1;
               end
            end
            S_REQ: begin
               if (cpu_ina) begin
                  r_state <= S_SERV;
                  r_int   <= 1'b0;
                  r_nmi   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_SERV: begin
               if (cpu_eoi) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_vec   <= '0;
               end else if (!r_src_nmi && r_nmi_p) begin
                  r_state    <= S_NREQ;
                  r_save_vec <= r_vec;
                  r_vec      <= NMI_VECTOR;
                  r_nmi      <= 1'b1;
               end
            end
            S_NREQ: begin
               if (cpu_ina) begin
                  r_state <= S_NSERV;
                  r_nmi   <= 1'b0;
               end
            end
            S_NSERV: begin
               if (cpu_eoi) begin
                  r_state <= S_SERV;
                  r_vec   <= r_save_vec;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cpu_int = r_int;
   assign cpu_nmi = r_nmi;
   assign vector  = r_vec;
   assign busy    = r_busy;
   assign pending = r_pend;

endmodule
